// File: rtl/log2_pkg.sv
// Shared types and sizing helpers for the log2 pipeline.
package log2_pkg;

  typedef enum logic {
    LOG2_FLOOR = 1'b0,
    LOG2_CEIL  = 1'b1
  } log2_mode_e;

  // Result must hold 0..width (ceil of an all-ones operand reaches width).
  function automatic int log2_out_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/log2_lod.sv
// Leading-one detector: MSB index of a vector plus a power-of-two flag.
module log2_lod #(
  parameter int WIDTH = 19,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] msb_idx_o,
  output logic             one_hot_o
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    msb_idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) msb_idx_o = IDX_W'(i);
    end
  end

  assign one_hot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/log2_pipe.sv
// Two-stage floor/ceil log2 pipeline with a saturating zero-operand counter.
module log2_pipe
  import log2_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int OUT_W = log2_out_w(WIDTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_val,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_log,
  output logic             out_zero,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  // Handshake: a beat transfers on a rising edge where valid && ready; valid
  // never depends on ready, and a stage advances when it is empty or drains.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_val_q;
  log2_mode_e       s1_mode_q;
  logic             s2_valid_q;
  logic [OUT_W-1:0] s2_log_q;
  logic             s2_zero_q;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  logic             s1_en, s2_en;
  logic [IDX_W-1:0] msb_idx;
  logic             one_hot;
  logic [OUT_W-1:0] log_d;
  logic             zero_d;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  log2_lod #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_lod (
    .vec_i    (s1_val_q),
    .msb_idx_o(msb_idx),
    .one_hot_o(one_hot)
  );

  always_comb begin
    log_d  = OUT_W'(msb_idx);
    zero_d = 1'b0;
    if (s1_val_q == '0) begin
      log_d  = '0;
      zero_d = 1'b1;
    end else if (s1_mode_q == LOG2_CEIL && !one_hot) begin
      log_d = OUT_W'(msb_idx) + OUT_W'(1);
    end
  end

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (in_valid && s1_en && (in_val == '0) && (zero_cnt_q != '1)) begin
      zero_cnt_d = zero_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s1_mode_q  <= LOG2_FLOOR;
      s2_valid_q <= 1'b0;
      s2_log_q   <= '0;
      s2_zero_q  <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_val_q  <= in_val;
          s1_mode_q <= log2_mode_e'(in_mode);
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_log_q  <= log_d;
          s2_zero_q <= zero_d;
        end
      end
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_log   = s2_log_q;
  assign out_zero  = s2_zero_q;
  assign zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_log2_pipe.sv
// Directed and random checks of log2_pipe, plus a CNT_W=2 instance for saturation.
module tb_log2_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_zero;
  logic [18:0] in_val;
  logic [4:0]  out_log;
  logic [15:0] zero_cnt;

  logic        sat_in_valid, sat_in_ready, sat_in_mode, sat_out_valid, sat_out_ready, sat_out_zero;
  logic [18:0] sat_in_val;
  logic [4:0]  sat_out_log;
  logic [1:0]  sat_zero_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [15:0] model_zcnt = '0;
  logic [5:0]  exp_q[$];
  logic [5:0]  mon_e;

  typedef struct {
    logic [18:0] val;
    logic        mode;
    logic [4:0]  elog;
    logic        ezero;
    logic [15:0] zc;
  } vec_t;
  vec_t vecs[11];

  log2_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_log(out_log), .out_zero(out_zero),
    .zero_cnt(zero_cnt)
  );

  log2_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_val(sat_in_val), .in_mode(sat_in_mode),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready), .out_log(sat_out_log),
    .out_zero(sat_out_zero), .zero_cnt(sat_zero_cnt)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_log2(input logic [18:0] v, input logic m);
    logic [4:0] idx;
    idx = '0;
    if (v == '0) return 6'b100000;
    for (int i = 0; i < 19; i++) if (v[i]) idx = 5'(i);
    if (m && ((v & (v - 19'd1)) != '0)) idx = idx + 5'd1;
    return {1'b0, idx};
  endfunction

  // Driver: call just after a rising edge; returns just after the accepting edge.
  task automatic drive_op(input logic [18:0] v, input logic m, input logic [4:0] elog,
                          input logic ezero, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_val = v;
    in_mode = m;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back({ezero, elog});
        if (v == '0 && model_zcnt != 16'hFFFF) model_zcnt = model_zcnt + 16'd1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  // Scoreboard: a result presented with out_ready high transfers on the next edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_log", {59'd0, out_log}, {59'd0, mon_e[4:0]});
        chk("out_zero", {63'd0, out_zero}, {63'd0, mon_e[5]});
      end
      xfer_cnt++;
      if (xfer_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, wsum;
    int sat_exp[5];
    logic [18:0] rv;
    logic rm;

    vecs = '{
      '{19'd1,       1'b0, 5'd0,  1'b0, 16'd0},
      '{19'h40000,   1'b0, 5'd18, 1'b0, 16'd0},
      '{19'h40000,   1'b1, 5'd18, 1'b0, 16'd0},
      '{19'h40001,   1'b1, 5'd19, 1'b0, 16'd0},
      '{19'h7FFFF,   1'b1, 5'd19, 1'b0, 16'd0},
      '{19'h7FFFF,   1'b0, 5'd18, 1'b0, 16'd0},
      '{19'd1,       1'b1, 5'd0,  1'b0, 16'd0},
      '{19'd3,       1'b0, 5'd1,  1'b0, 16'd0},
      '{19'd3,       1'b1, 5'd2,  1'b0, 16'd0},
      '{19'd0,       1'b0, 5'd0,  1'b1, 16'd1},
      '{19'd0,       1'b1, 5'd0,  1'b1, 16'd2}
    };
    sat_exp = '{1, 2, 3, 3, 3};

    reset_n = 1'b0;
    in_valid = 1'b0; in_val = '0; in_mode = 1'b0; out_ready = 1'b1;
    sat_in_valid = 1'b0; sat_in_val = '0; sat_in_mode = 1'b0; sat_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_zero_cnt", {48'd0, zero_cnt}, 64'd0);
    chk("rst_sat_zero_cnt", {62'd0, sat_zero_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Single operands: check 2-cycle latency and zero counting.
    foreach (vecs[i]) begin
      drive_op(vecs[i].val, vecs[i].mode, vecs[i].elog, vecs[i].ezero, w);
      chk("zero_cnt", {48'd0, zero_cnt}, {48'd0, vecs[i].zc});
      @(negedge clk);
      chk("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end

    // Backpressure: two accepts fill the pipe, third waits until out_ready rises.
    out_ready = 1'b0;
    fork
      begin
        drive_op(19'h40000, 1'b0, 5'd18, 1'b0, w);
        drive_op(19'd3, 1'b1, 5'd2, 1'b0, w);
        drive_op(19'd0, 1'b1, 5'd0, 1'b1, w);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_hold_log", {59'd0, out_log}, 64'd18);
          chk("bp_hold_zero", {63'd0, out_zero}, 64'd0);
          chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
          chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_zero_cnt", {48'd0, zero_cnt}, 64'd3);

    // Throughput: 100 random operands back-to-back.
    xfer_cnt = 0;
    wsum = 0;
    for (int i = 0; i < 100; i++) begin
      rv = ($urandom_range(0, 7) == 0) ? 19'd0 : 19'($urandom());
      if ($urandom_range(0, 3) == 0) rv = rv >> $urandom_range(0, 18);
      rm = 1'($urandom_range(0, 1));
      mon_e = ref_log2(rv, rm);
      drive_op(rv, rm, mon_e[4:0], mon_e[5], w);
      wsum += w;
    end
    drain();
    chk("tp_stalls", 64'(wsum), 64'd0);
    chk("tp_results", 64'(xfer_cnt), 64'd100);
    chk("tp_span", 64'(last_cyc - first_cyc), 64'd99);
    chk("tp_zero_cnt", {48'd0, zero_cnt}, {48'd0, model_zcnt});

    // Reset with two operands in flight.
    drive_op(19'd0, 1'b0, 5'd0, 1'b1, w);
    drive_op(19'd5, 1'b0, 5'd2, 1'b0, w);
    chk("pre_rst_zero_cnt", {48'd0, zero_cnt}, {48'd0, model_zcnt});
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_zero_cnt", {48'd0, zero_cnt}, 64'd0);
    exp_q.delete();
    model_zcnt = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    end
    chk("post_rst_zero_cnt", {48'd0, zero_cnt}, 64'd0);
    @(posedge clk);
    #1;

    // Saturation on the CNT_W=2 instance.
    sat_in_valid = 1'b1;
    sat_in_val = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sat_in_ready", {63'd0, sat_in_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk("sat_zero_cnt", {62'd0, sat_zero_cnt}, 64'(sat_exp[i]));
    end
    sat_in_valid = 1'b0;

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
